alu_request_arbiter: RTL and testbench
======================================

# alu_request_arbiter

Round-robin arbiter that shares the single atomic ALU controller among N requesters (cores or DMA agents), each issuing 12-bit ALU/CAS commands. It selects one pending requester, latches its command, pulses the controller's run (syscall) input, waits for completion or a watchdog timeout, then returns a one-cycle acknowledge to the winner. It sits directly upstream of the ALU controller's `command` and `syscall` inputs and serialises all command traffic so a CAS sequence is never interleaved with another command.

## Interface
- `N_REQ`, 4: number of requesters (2..8).
- `CMD_W`, 12: command width; the command is forwarded opaquely.
- `TIMEOUT`, 15: maximum WAIT cycles before abort (1..255).

- `clk`  in  1  clock; all state changes on its rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `req`  in  N_REQ  per-requester level request; held until its `ack`.
- `cmd_in`  in  N_REQ*CMD_W  packed commands; requester i uses bits [i*CMD_W +: CMD_W], stable while `req[i]` is high.
- `ack`  out  N_REQ  one-cycle completion pulse to the granted requester.
- `timeout`  out  1  valid with `ack`: 1 means aborted by the watchdog.
- `run`  out  1  one-cycle start pulse to the controller's `syscall`.
- `cmd_out`  out  CMD_W  latched command to the controller's `command`.
- `done`  in  1  controller completion pulse (returned to IDLE).
- `busy`  out  1  high in every state except IDLE.
- `grant_id`  out  $clog2(N_REQ)  index of the current or most recent winner.

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE: if any `req` bit is high, select the winner by round-robin, latch `grant_id` and its `cmd_in` slice into `cmd_out`, and go to ISSUE. Otherwise stay in IDLE.
- Round-robin: the search starts at `(last + 1) mod N_REQ` and takes the first high bit. `last` is updated to the winner only in RESP. After reset `last = N_REQ-1`, so requester 0 has highest priority first.
- ISSUE: `run`=1 for exactly this cycle, then go to WAIT. Clear the watchdog counter.
- WAIT: the counter increments each cycle. `done`=1 → RESP with `timeout`=0. If the counter reaches `TIMEOUT` without `done` → RESP with `timeout`=1. If both happen in the same cycle, `done` wins (`timeout`=0).
- RESP: `ack[grant_id]`=1 and `timeout` is valid for this cycle only. Update `last`, then go to IDLE.
- `cmd_out` holds its value from the latch until the next grant, so it stays stable through ISSUE and WAIT.
- `done` is ignored in IDLE, ISSUE and RESP; no state or output changes.
- Changes on `req` or `cmd_in` after the latch have no effect on the transaction in flight.
- A requester still holding `req` in the cycle after its `ack` is re-eligible, but goes behind all other pending requesters.
- Counter width is 8 bits, saturating; no wrap is possible since `TIMEOUT` ≤ 255.

## Timing
- Reset values: `run`=0, `ack`=0, `timeout`=0, `busy`=0, `cmd_out`=0, `grant_id`=0, `last`=N_REQ-1, state IDLE, counter 0.
- Reset assertion mid-transaction forces the reset values immediately (asynchronously). No `ack` is issued for the aborted request.
- Let `req` be sampled high in IDLE at edge k:
  - `run` is high in cycle k+1 (ISSUE).
  - WAIT begins at cycle k+2.
  - If `done` is sampled at edge m (m ≥ k+2), `ack` is high in cycle m+1.
  - The FSM is back in IDLE at cycle m+2 and can grant on that edge.
- Minimum request-to-ack latency is 3 cycles; throughput is one transaction per at least 4 cycles.
- With no `done`, `ack` with `timeout`=1 appears in cycle k+2+TIMEOUT.
- All outputs are registered; no combinational path exists from `req`, `cmd_in` or `done` to any output.

## Test plan
- Single request: `req`=0001, `cmd_in[0]`=12'hE53, `done` three cycles after `run` → `run` one cycle with `cmd_out`=12'hE53, `ack`=0001 with `timeout`=0, `busy` returns to 0.
- Simultaneous requests: `req`=1111 held with `done` always returned → grants in order 0,1,2,3,0, each with a single `ack` bit and the matching `cmd_out`.
- Fairness: requester 2 re-requests immediately after its ack while 0 and 3 are pending → next grants are 3, then 0, then 2.
- Timeout: `TIMEOUT`=15, `done` never asserted → `ack` with `timeout`=1 exactly 17 cycles after the grant edge, then the next requester is served normally.
- `done` and timeout in the same cycle → `timeout`=0. A stray `done` in IDLE → no `ack`, no state change.
- Reset mid-WAIT: drop `rst_n` while `busy`=1 → all outputs go to their reset values at once, no `ack` is issued, and after release requester 0 wins first.

Source files
------------

// File: rtl/alu_request_arbiter.sv
// alu_request_arbiter: round-robin front end for the shared atomic ALU
// controller. It grants one requester at a time and latches that requester's
// command. It then pulses run and waits for done or the watchdog. Last, it
// returns a one-cycle ack with a timeout flag. Every output is registered.
module alu_request_arbiter #(
   parameter int N_REQ   = 4,
   parameter int CMD_W   = 12,
   parameter int TIMEOUT = 15
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic [N_REQ-1:0]           req,
   input  logic [N_REQ*CMD_W-1:0]     cmd_in,
   output logic [N_REQ-1:0]           ack,
   output logic                       timeout,
   output logic                       run,
   output logic [CMD_W-1:0]           cmd_out,
   input  logic                       done,
   output logic                       busy,
   output logic [$clog2(N_REQ)-1:0]   grant_id
);

   localparam int ID_W  = $clog2(N_REQ);
   localparam int CNT_W = 8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      RESP  = 2'd3
   } state_t;

   state_t            state_reg, state_next;
   logic              run_reg, run_next;
   logic [N_REQ-1:0]  ack_reg, ack_next;
   logic              timeout_reg, timeout_next;
   logic              busy_reg, busy_next;
   logic [CMD_W-1:0]  cmd_out_reg, cmd_out_next;
   logic [ID_W-1:0]   grant_id_reg, grant_id_next;
   logic [ID_W-1:0]   last_reg, last_next;
   logic [CNT_W-1:0]  cnt_reg, cnt_next;

   // Per-requester command slices, so the winner can be selected by index.
   logic [CMD_W-1:0]  cmd_slice [N_REQ];
   // Requester index examined at each search offset, and whether it is asking.
   logic [ID_W-1:0]   cand_idx [N_REQ];
   logic [N_REQ-1:0]  cand_hit;
   logic [ID_W-1:0]   win_id;
   logic              any_req;
   logic              wait_expire;

   genvar gi;
   generate
      for (gi = 0; gi < N_REQ; gi++) begin : g_slice
         assign cmd_slice[gi] = cmd_in[gi*CMD_W +: CMD_W];
         // Offset 0 is the requester right after the last winner.
         assign cand_idx[gi]  = ID_W'((32'(last_reg) + 32'(gi) + 32'd1) % 32'(N_REQ));
         assign cand_hit[gi]  = req[cand_idx[gi]];
      end
   endgenerate

   assign any_req = |req;

   // The first asking requester at the smallest offset wins. The loop walks the
   // offsets downwards, so the lowest offset is assigned last and takes effect.
   always_comb begin
      win_id = '0;
      for (int i = N_REQ - 1; i >= 0; i--) begin
         if (cand_hit[i]) begin
            win_id = cand_idx[i];
         end
      end
   end

   // The watchdog fires on the WAIT edge that takes the counter to TIMEOUT.
   // The sum is one bit wider, so a counter value of 255 cannot wrap.
   assign wait_expire = ({1'b0, cnt_reg} + 9'd1) >= 9'(TIMEOUT);

   // State, registered outputs, the round-robin pointer and the watchdog counter.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg    <= IDLE;
         run_reg      <= 1'b0;
         ack_reg      <= '0;
         timeout_reg  <= 1'b0;
         busy_reg     <= 1'b0;
         cmd_out_reg  <= '0;
         grant_id_reg <= '0;
         last_reg     <= ID_W'(N_REQ - 1);
         cnt_reg      <= '0;
      end else begin
         state_reg    <= state_next;
         run_reg      <= run_next;
         ack_reg      <= ack_next;
         timeout_reg  <= timeout_next;
         busy_reg     <= busy_next;
         cmd_out_reg  <= cmd_out_next;
         grant_id_reg <= grant_id_next;
         last_reg     <= last_next;
         cnt_reg      <= cnt_next;
      end
   end

   // Next-state logic. Output values are computed one cycle early, so that each
   // output shows up in the same cycle as the state it belongs to.
   always_comb begin
      state_next    = state_reg;
      run_next      = 1'b0;
      ack_next      = '0;
      timeout_next  = 1'b0;
      cmd_out_next  = cmd_out_reg;
      grant_id_next = grant_id_reg;
      last_next     = last_reg;
      cnt_next      = cnt_reg;

      case (state_reg)
         IDLE: begin
            // done is ignored here. Only a request can start a transaction.
            if (any_req) begin
               grant_id_next = win_id;
               cmd_out_next  = cmd_slice[win_id];
               run_next      = 1'b1;
               state_next    = ISSUE;
            end
         end
         ISSUE: begin
            cnt_next   = '0;
            state_next = WAIT;
         end
         WAIT: begin
            cnt_next = (cnt_reg == {CNT_W{1'b1}}) ? cnt_reg : cnt_reg + 8'd1;
            // If done and the watchdog expire on the same edge, done wins.
            if (done) begin
               ack_next[grant_id_reg] = 1'b1;
               state_next             = RESP;
            end else if (wait_expire) begin
               ack_next[grant_id_reg] = 1'b1;
               timeout_next           = 1'b1;
               state_next             = RESP;
            end
         end
         RESP: begin
            // The pointer moves only after completion. A requester that asks
            // again right away therefore goes behind the others that are waiting.
            last_next  = grant_id_reg;
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   assign busy_next = (state_next != IDLE);

   assign run      = run_reg;
   assign ack      = ack_reg;
   assign timeout  = timeout_reg;
   assign busy     = busy_reg;
   assign cmd_out  = cmd_out_reg;
   assign grant_id = grant_id_reg;

endmodule

// File: tb/tb_alu_request_arbiter.sv
// Directed bench for alu_request_arbiter. Each expected grant goes onto a
// scoreboard when its request is driven. The entry is popped and compared when
// the DUT acks. Inputs are driven and outputs sampled on the falling edge.
module tb_alu_request_arbiter;

   localparam int N_REQ   = 4;
   localparam int CMD_W   = 12;
   localparam int TIMEOUT = 15;
   localparam int ID_W    = $clog2(N_REQ);

   typedef struct packed {
      logic [ID_W-1:0]  id;
      logic [CMD_W-1:0] cmd;
      logic             to;
   } exp_t;

   logic                     clk;
   logic                     rst_n;
   logic [N_REQ-1:0]         req;
   logic [N_REQ*CMD_W-1:0]   cmd_in;
   logic [N_REQ-1:0]         ack;
   logic                     timeout;
   logic                     run;
   logic [CMD_W-1:0]         cmd_out;
   logic                     done;
   logic                     busy;
   logic [ID_W-1:0]          grant_id;

   int   n_cmp;
   int   n_err;
   exp_t sb[$];
   logic [CMD_W-1:0] cmds [N_REQ];

   alu_request_arbiter #(
      .N_REQ   (N_REQ),
      .CMD_W   (CMD_W),
      .TIMEOUT (TIMEOUT)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .req      (req),
      .cmd_in   (cmd_in),
      .ack      (ack),
      .timeout  (timeout),
      .run      (run),
      .cmd_out  (cmd_out),
      .done     (done),
      .busy     (busy),
      .grant_id (grant_id)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Safety net so that the run always terminates.
   initial begin
      #2000000;
      $display("FAIL global_timeout: observed no finish, required finish");
      $fatal(1, "simulation time limit");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic expect_grant(input int id, input bit to);
      exp_t e;
      e.id  = ID_W'(id);
      e.cmd = cmds[id];
      e.to  = to;
      sb.push_back(e);
   endtask

   // Serve the transaction at the head of the scoreboard. With give_done set,
   // done is driven dly cycles after the run cycle (dly >= 1). Without it, the
   // watchdog ends the transaction. ack must appear exactly at the predicted
   // cycle: after edge m when done is sampled at m, or after edge
   // grant+1+TIMEOUT on a timeout.
   task automatic serve(input int dly, input bit give_done, input bit keep);
      exp_t e;
      bit   seen;
      bit   early;
      int   n;
      if (sb.size() == 0) begin
         check("sb_nonempty", 32'd0, 32'd1);
         return;
      end
      e    = sb[0];
      seen = 1'b0;
      for (int c = 0; c < 20 && !seen; c++) begin
         if (run === 1'b1) seen = 1'b1;
         else tick();
      end
      check("run_seen", 32'(seen), 32'd1);
      if (!seen) return;
      check("issue_cmd_out", 32'(cmd_out), 32'(e.cmd));
      check("issue_grant_id", 32'(grant_id), 32'(e.id));
      check("issue_busy", 32'(busy), 32'd1);
      early = 1'b0;
      n = give_done ? dly + 1 : TIMEOUT + 1;
      for (int t = 1; t <= n; t++) begin
         tick();
         done = 1'b0;
         if (t == 1) check("run_one_cycle", 32'(run), 32'd0);
         if (t < n && ack !== '0) early = 1'b1;
         if (give_done && t == dly) done = 1'b1;
      end
      e = sb.pop_front();
      $display("txn: id=%0d cmd=%03h ack=%b timeout=%b cmd_out=%03h",
               e.id, e.cmd, ack, timeout, cmd_out);
      check("ack_not_early", 32'(early), 32'd0);
      check("ack_onehot", 32'(ack), 32'(1) << e.id);
      check("ack_timeout", 32'(timeout), 32'(e.to));
      check("ack_grant_id", 32'(grant_id), 32'(e.id));
      check("ack_cmd_out", 32'(cmd_out), 32'(e.cmd));
      if (!keep) req[e.id] = 1'b0;
      tick();
      check("ack_one_cycle", 32'(ack), 32'd0);
      check("timeout_one_cycle", 32'(timeout), 32'd0);
   endtask

   initial begin
      n_cmp   = 0;
      n_err   = 0;
      rst_n   = 1'b0;
      req     = '0;
      done    = 1'b0;
      cmds[0] = 12'hE53;
      cmds[1] = 12'h0A1;
      cmds[2] = 12'h5C7;
      cmds[3] = 12'hB3D;
      for (int i = 0; i < N_REQ; i++) cmd_in[i*CMD_W +: CMD_W] = cmds[i];

      // Values while in reset.
      tick();
      check("rst_run", 32'(run), 32'd0);
      check("rst_ack", 32'(ack), 32'd0);
      check("rst_timeout", 32'(timeout), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_cmd_out", 32'(cmd_out), 32'd0);
      check("rst_grant_id", 32'(grant_id), 32'd0);
      tick();
      rst_n = 1'b1;
      tick();

      // Single request, with done three cycles after run.
      req = 4'b0001;
      expect_grant(0, 1'b0);
      serve(3, 1'b1, 1'b0);
      check("single_busy_clear", 32'(busy), 32'd0);

      // All four requesters holding their requests, starting from reset order.
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      tick();
      req = 4'b1111;
      expect_grant(0, 1'b0); serve(1, 1'b1, 1'b1);
      expect_grant(1, 1'b0); serve(1, 1'b1, 1'b1);
      expect_grant(2, 1'b0); serve(1, 1'b1, 1'b1);
      expect_grant(3, 1'b0); serve(1, 1'b1, 1'b1);
      expect_grant(0, 1'b0); serve(1, 1'b1, 1'b1);
      req = '0;

      // Fairness: 2 asks again right after its ack while 0 and 3 are waiting.
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      tick();
      req = 4'b0010;
      expect_grant(1, 1'b0); serve(2, 1'b1, 1'b0);
      req = 4'b1101;
      expect_grant(2, 1'b0); serve(2, 1'b1, 1'b1);
      expect_grant(3, 1'b0); serve(2, 1'b1, 1'b0);
      expect_grant(0, 1'b0); serve(2, 1'b1, 1'b0);
      expect_grant(2, 1'b0); serve(2, 1'b1, 1'b0);

      // Watchdog: 0 never gets done, and 1 is then served normally (last = 2).
      req = 4'b0011;
      expect_grant(0, 1'b1); serve(0, 1'b0, 1'b0);
      expect_grant(1, 1'b0); serve(2, 1'b1, 1'b0);

      // done on the same edge the watchdog would fire: done wins.
      req = 4'b0100;
      expect_grant(2, 1'b0); serve(TIMEOUT, 1'b1, 1'b0);

      // A stray done in IDLE changes nothing.
      done = 1'b1;
      tick();
      done = 1'b0;
      tick();
      check("stray_done_ack", 32'(ack), 32'd0);
      check("stray_done_busy", 32'(busy), 32'd0);
      check("stray_done_run", 32'(run), 32'd0);
      check("stray_done_grant_id", 32'(grant_id), 32'd2);

      // Reset in the middle of WAIT (last = 2, so 3 wins here).
      req = 4'b1000;
      expect_grant(3, 1'b0);
      for (int c = 0; c < 20 && run !== 1'b1; c++) tick();
      check("rst_mid_run_seen", 32'(run), 32'd1);
      tick();
      tick();
      check("rst_mid_busy_before", 32'(busy), 32'd1);
      rst_n = 1'b0;
      #1;
      check("rst_mid_busy", 32'(busy), 32'd0);
      check("rst_mid_cmd_out", 32'(cmd_out), 32'd0);
      check("rst_mid_grant_id", 32'(grant_id), 32'd0);
      check("rst_mid_run", 32'(run), 32'd0);
      // The aborted transaction is never acked, so drop its scoreboard entry.
      sb.delete();
      req = 4'b1001;
      tick();
      check("rst_mid_no_ack", 32'(ack), 32'd0);
      tick();
      rst_n = 1'b1;
      expect_grant(0, 1'b0); serve(2, 1'b1, 1'b0);
      req = '0;
      tick();
      check("rst_mid_no_late_ack", 32'(ack), 32'd0);

      check("sb_drained", 32'(sb.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
